// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: FSM states, GF(2^8) helpers and
// column-major byte indexing used by ShiftRows/MixColumns and Substitute.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MIX    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [7:0] RED_POLY = 8'h1B;
    localparam int         ROWS     = 4;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? RED_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

    // Byte k = 4c+r sits at data[127-8k -: 8]; 15-k is simply ~{c,r}.
    function automatic logic [6:0] byte_lsb(
        input logic [1:0] r,
        input logic [1:0] c
    );
        return {~c, ~r, 3'b000};
    endfunction

    function automatic logic [7:0] state_byte(
        input logic [127:0] s,
        input logic [1:0]   r,
        input logic [1:0]   c
    );
        return s[byte_lsb(r, c) +: 8];
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// MixColumns transform of one 32-bit state column (a0 in the top byte).
module mix_single_column
    import aes_pkg::*;
(
    input  logic [31:0] column,
    output logic [31:0] mixed
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;

    assign a0 = column[31:24];
    assign a1 = column[23:16];
    assign a2 = column[15:8];
    assign a3 = column[7:0];

    assign b0 = xtime(a0) ^ gmul3(a1) ^ a2 ^ a3;
    assign b1 = a0 ^ xtime(a1) ^ gmul3(a2) ^ a3;
    assign b2 = a0 ^ a1 ^ xtime(a2) ^ gmul3(a3);
    assign b3 = gmul3(a0) ^ a1 ^ a2 ^ xtime(a3);

    assign mixed = {b0, b1, b2, b3};

endmodule

// File: rtl/shift_mix.sv
// AES ShiftRows + iterative MixColumns round stage, one column per clock,
// with a bypass path for the final round.
module shift_mix
    import aes_pkg::*;
#(
    parameter int COLS = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         load,
    input  logic         bypass_mix,
    input  logic [127:0] data_in,
    output logic [127:0] data_out,
    output logic         busy,
    output logic         done
);

    state_t       state, state_n;
    logic [1:0]   col, col_n;
    logic [127:0] work, work_n;
    logic [127:0] out_n;
    logic         done_n;
    logic [127:0] shifted;
    logic [31:0]  col_word;
    logic [31:0]  col_mixed;

    always_comb begin
        shifted = '0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                shifted[byte_lsb(2'(r), 2'(c)) +: 8] =
                    state_byte(data_in, 2'(r), 2'(c + r));
            end
        end
    end

    // Column col occupies work[127-32*col -: 32], i.e. base 32*(3-col).
    assign col_word = work[{~col, 5'b0} +: 32];

    mix_single_column u_mix (
        .column (col_word),
        .mixed  (col_mixed)
    );

    always_comb begin
        state_n = state;
        col_n   = col;
        work_n  = work;
        out_n   = data_out;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (load) begin
                    work_n  = shifted;
                    col_n   = 2'd0;
                    state_n = bypass_mix ? FINISH : MIX;
                end
            end
            MIX: begin
                work_n[{~col, 5'b0} +: 32] = col_mixed;
                col_n = col + 2'd1;
                if (col == 2'(COLS - 1)) begin
                    state_n = FINISH;
                end
            end
            FINISH: begin
                out_n   = work;
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= IDLE;
            col      <= 2'd0;
            work     <= '0;
            data_out <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            col      <= col_n;
            work     <= work_n;
            data_out <= out_n;
            done     <= done_n;
        end
    end

    assign busy = (state != IDLE);

endmodule
